// File: rtl/mem_region_checker_pkg.sv
// mem_region_checker_pkg: shared state encoding and read-latency limits for the region checker
package mem_region_checker_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_region_checker_rd_lat_pipe.sv
// rd_lat_pipe: valid/payload delay line matching the SRAM read latency
// pending flags valid entries that have not yet reached the output stage.
module rd_lat_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         pending
);

    localparam logic [DEPTH-1:0] TOP = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0] v;
    logic [W-1:0]     d [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid && !flush;
            d[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1] && !flush;
                d[i] <= d[i-1];
            end
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign pending   = |(v & ~TOP);

endmodule

// File: rtl/mem_region_checker.sv
// mem_region_checker: streams two SRAM regions word by word and reports mismatches
// Reads are issued back to back; compares happen as each response returns RD_LAT cycles later.
module mem_region_checker
    import mem_region_checker_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] res_base,
    input  logic [ADDR_W-1:0] ref_base,
    input  logic [LEN_W-1:0]  length,
    output logic              res_rd_en,
    output logic [ADDR_W-1:0] res_rd_addr,
    input  logic [DATA_W-1:0] res_rd_data,
    output logic              ref_rd_en,
    output logic [ADDR_W-1:0] ref_rd_addr,
    input  logic [DATA_W-1:0] ref_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [LEN_W-1:0]  mismatch_cnt,
    output logic [LEN_W-1:0]  first_idx,
    output logic [DATA_W-1:0] first_exp,
    output logic [DATA_W-1:0] first_got
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_region_checker: RD_LAT out of range");
    end

    state_e            state, state_nx;
    logic [ADDR_W-1:0] res_base_q, ref_base_q;
    logic [LEN_W-1:0]  len_q, idx, cmp_idx, cnt_nx;
    logic              accept, kill, issue, cmp_valid, pending, miss;

    assign accept = state == IDLE && start && !abort;
    assign kill   = state != IDLE && abort;
    assign issue  = state == ISSUE && !abort;
    assign miss   = cmp_valid && !kill && res_rd_data != ref_rd_data;
    assign cnt_nx = mismatch_cnt + LEN_W'(miss);

    assign res_rd_en   = issue;
    assign ref_rd_en   = issue;
    assign res_rd_addr = issue ? res_base_q + ADDR_W'(idx) : '0;
    assign ref_rd_addr = issue ? ref_base_q + ADDR_W'(idx) : '0;
    assign busy        = state != IDLE;
    assign done        = state == DONE && !abort;

    rd_lat_pipe #(.DEPTH(RD_LAT), .W(LEN_W)) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (kill),
        .in_valid (issue),
        .in_data  (idx),
        .out_valid(cmp_valid),
        .out_data (cmp_idx),
        .pending  (pending)
    );

    always_comb begin
        state_nx = state;
        if (kill) state_nx = IDLE;
        else case (state)
            IDLE:    state_nx = accept ? (length == '0 ? DONE : ISSUE) : IDLE;
            ISSUE:   state_nx = idx == len_q - 1'b1 ? DRAIN : ISSUE;
            DRAIN:   state_nx = pending ? DRAIN : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            res_base_q   <= '0;
            ref_base_q   <= '0;
            len_q        <= '0;
            idx          <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_exp    <= '0;
            first_got    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                res_base_q   <= res_base;
                ref_base_q   <= ref_base;
                len_q        <= length;
                idx          <= '0;
                pass         <= length == '0;
                mismatch_cnt <= '0;
                first_idx    <= '0;
                first_exp    <= '0;
                first_got    <= '0;
            end else begin
                if (issue) idx <= idx + 1'b1;
                if (miss) begin
                    mismatch_cnt <= cnt_nx;
                    if (mismatch_cnt == '0) begin
                        first_idx <= cmp_idx;
                        first_exp <= ref_rd_data;
                        first_got <= res_rd_data;
                    end
                end
                // the final compare lands on the DRAIN->DONE edge, so pass must see cnt_nx
                if (kill) pass <= 1'b0;
                else if (state == DRAIN && !pending) pass <= cnt_nx == '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_region_checker.sv
// tb_mem_region_checker: checks RD_LAT=1 and RD_LAT=2 checkers side by side against a cycle-level model
module tb_mem_region_checker;

    localparam longint NEVER = 64'h7fff_ffff_ffff;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [31:0] res_base, ref_base;
    logic [15:0] length;

    logic        busy [2], done [2], pass [2], res_en [2], ref_en [2];
    logic [31:0] res_addr [2], ref_addr [2];
    logic [63:0] res_data [2], ref_data [2], f_exp [2], f_got [2];
    logic [15:0] cnt [2], f_idx [2];

    bit [63:0] res_mem [bit [31:0]];
    bit [63:0] ref_mem [bit [31:0]];

    longint cyc = 0;
    bit     run_valid;
    longint t0, abort_cyc;
    int     len, e_cnt, s_cnt;
    logic [31:0] rb, fb;
    logic [15:0] e_idx, s_idx;
    logic [63:0] e_exp, e_got, s_exp, s_got;

    int     n_vec = 0, n_err = 0;
    int     done_n [2], rd_n [2];
    longint done_at [2];
    logic [31:0] addr_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rd_mem(input bit is_res, input logic [31:0] a);
        if (is_res) return res_mem.exists(a) ? res_mem[a] : {32'h5e5e_5e5e, a};
        return ref_mem.exists(a) ? ref_mem[a] : {32'hc0de_c0de, a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [63:0] rq [2], fq [2];
        always @(posedge clk) begin
            rq[0] <= rd_mem(1'b1, res_addr[g]);
            rq[1] <= rq[0];
            fq[0] <= rd_mem(1'b0, ref_addr[g]);
            fq[1] <= fq[0];
        end
        assign res_data[g] = rq[g];
        assign ref_data[g] = fq[g];
        mem_region_checker #(.RD_LAT(g + 1)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start),
            .abort       (abort),
            .res_base    (res_base),
            .ref_base    (ref_base),
            .length      (length),
            .res_rd_en   (res_en[g]),
            .res_rd_addr (res_addr[g]),
            .res_rd_data (res_data[g]),
            .ref_rd_en   (ref_en[g]),
            .ref_rd_addr (ref_addr[g]),
            .ref_rd_data (ref_data[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .pass        (pass[g]),
            .mismatch_cnt(cnt[g]),
            .first_idx   (f_idx[g]),
            .first_exp   (f_exp[g]),
            .first_got   (f_got[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // Expected outputs follow from the run timeline: reads in t0+1..t0+L, done at t0+L+lat+1.
    task automatic check_dut(input int g);
        longint c = cyc, dc, endc;
        bit ab, e_rd, e_busy = 0, e_done = 0, e_pass = 0, chk_res = 1, chk_pass = 1;
        logic [31:0] e_ra = 0, e_fa = 0;
        int x_cnt = 0;
        logic [15:0] x_idx = 0;
        logic [63:0] x_exp = 0, x_got = 0;
        string s = $sformatf("[lat%0d]", g + 1);
        if (rst_n && run_valid) begin
            dc   = len == 0 ? t0 + 1 : t0 + len + g + 2;
            ab   = abort_cyc <= dc;
            endc = ab ? abort_cyc + 1 : dc + 1;
            e_rd = c > t0 && c <= t0 + len && c < abort_cyc;
            e_busy = c > t0 && c < endc;
            e_done = !ab && c == dc;
            e_ra = e_rd ? rb + 32'(c - t0 - 1) : 32'd0;
            e_fa = e_rd ? fb + 32'(c - t0 - 1) : 32'd0;
            chk_res  = !ab && c >= dc;
            chk_pass = chk_res || c > t0;
            if (chk_res) begin
                e_pass = e_cnt == 0;
                x_cnt = e_cnt; x_idx = e_idx; x_exp = e_exp; x_got = e_got;
            end
        end
        chk({"busy", s}, 64'(busy[g]), 64'(e_busy));
        chk({"done", s}, 64'(done[g]), 64'(e_done));
        chk({"res_rd_en", s}, 64'(res_en[g]), 64'(e_rd));
        chk({"ref_rd_en", s}, 64'(ref_en[g]), 64'(e_rd));
        chk({"res_rd_addr", s}, 64'(res_addr[g]), 64'(e_ra));
        chk({"ref_rd_addr", s}, 64'(ref_addr[g]), 64'(e_fa));
        if (chk_pass) chk({"pass", s}, 64'(pass[g]), 64'(e_pass));
        if (chk_res) begin
            chk({"mismatch_cnt", s}, 64'(cnt[g]), 64'(x_cnt));
            chk({"first_idx", s}, 64'(f_idx[g]), 64'(x_idx));
            chk({"first_exp", s}, f_exp[g], x_exp);
            chk({"first_got", s}, f_got[g], x_got);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            check_dut(g);
            if (done[g]) begin
                done_n[g]++;
                done_at[g] = cyc;
            end
            if (res_en[g]) begin
                rd_n[g]++;
                if (g == 0) addr_q.push_back(res_addr[0]);
            end
        end
    end

    task automatic setup(input logic [31:0] r, input logic [31:0] f, input int l, input int pct,
                         input int fix1, input int fix2);
        logic [63:0] d, a, b;
        res_mem.delete();
        ref_mem.delete();
        for (int i = 0; i < l; i++) begin
            d = {$urandom, $urandom};
            ref_mem[f + 32'(i)] = d;
            res_mem[r + 32'(i)] = (i == fix1 || i == fix2 || $urandom_range(99) < pct)
                                  ? d ^ ({$urandom, $urandom} | 64'd1) : d;
        end
        s_cnt = 0; s_idx = 0; s_exp = 0; s_got = 0;
        for (int i = 0; i < l; i++) begin
            a = res_mem[r + 32'(i)];
            b = ref_mem[f + 32'(i)];
            if (a != b) begin
                if (s_cnt == 0) begin
                    s_idx = 16'(i); s_exp = b; s_got = a;
                end
                s_cnt++;
            end
        end
    endtask

    task automatic go(input logic [31:0] r, input logic [31:0] f, input int l);
        @(posedge clk); #1;
        start = 1'b1; res_base = r; ref_base = f; length = 16'(l);
        run_valid = 1'b1; t0 = cyc; len = l; rb = r; fb = f; abort_cyc = NEVER;
        e_cnt = s_cnt; e_idx = s_idx; e_exp = s_exp; e_got = s_got;
        done_n = '{0, 0}; rd_n = '{0, 0}; done_at = '{0, 0};
        addr_q.delete();
        @(posedge clk); #1;
        start = 1'b0; res_base = $urandom; ref_base = $urandom; length = 16'($urandom);
    endtask

    task automatic run(input logic [31:0] r, input logic [31:0] f, input int l, input int pct,
                       input int fix1, input int fix2, input int ab_off, input bit spur);
        setup(r, f, l, pct, fix1, fix2);
        go(r, f, l);
        while (cyc < t0 + len + 5) begin
            abort = ab_off != 0 && cyc == t0 + ab_off;
            if (abort) abort_cyc = cyc;
            start = spur && cyc == t0 + 1;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] wrap_exp [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        int l, ab;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        res_base = '0; ref_base = '0; length = '0;
        run_valid = 1'b0; t0 = 0; len = 0; abort_cyc = NEVER;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(busy[0]), 64'd0);
        chk("reset_pass", 64'(pass[1]), 64'd0);

        run(32'd2048, 32'd0, 512, 0, -1, -1, 0, 1'b0);
        chk("l512_done_latency", 64'(done_at[0] - t0), 64'd514);
        chk("l512_pass", 64'(pass[0]), 64'd1);
        chk("l512_cnt", 64'(cnt[0]), 64'd0);
        chk("l512_done_pulses", 64'(done_n[0]), 64'd1);

        run(32'h0001_0000, 32'h0002_0000, 128, 0, 5, 77, 0, 1'b0);
        chk("corrupt_cnt", 64'(cnt[1]), 64'd2);
        chk("corrupt_first_idx", 64'(f_idx[1]), 64'd5);
        chk("corrupt_first_exp", f_exp[1], ref_mem[32'h0002_0005]);
        chk("corrupt_first_got", f_got[1], res_mem[32'h0001_0005]);
        chk("corrupt_pass", 64'(pass[1]), 64'd0);
        chk("corrupt_done_latency", 64'(done_at[1] - t0), 64'd131);

        run(32'h100, 32'h200, 0, 0, -1, -1, 0, 1'b0);
        chk("zero_len_reads", 64'(rd_n[0] + rd_n[1]), 64'd0);
        chk("zero_len_done_latency", 64'(done_at[0] - t0), 64'd1);
        chk("zero_len_pass", 64'(pass[1]), 64'd1);

        run(32'h3000, 32'h4000, 64, 20, -1, -1, 10, 1'b0);
        chk("abort_no_done", 64'(done_n[0] + done_n[1]), 64'd0);
        chk("abort_reads", 64'(rd_n[0]), 64'd9);
        chk("abort_pass", 64'(pass[0]), 64'd0);
        run(32'h3000, 32'h4000, 4, 0, -1, -1, 0, 1'b0);
        chk("after_abort_pass", 64'(pass[0]), 64'd1);
        chk("after_abort_done", 64'(done_n[1]), 64'd1);

        run(32'hFFFF_FFFE, 32'h10, 4, 25, -1, -1, 0, 1'b1);
        chk("wrap_read_count", 64'(addr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap_addr%0d", i), 64'(addr_q.size() > i ? addr_q[i] : 32'hx), 64'(wrap_exp[i]));

        setup(32'h500, 32'h600, 8, 50, -1, -1);
        go(32'h500, 32'h600, 8);
        while (cyc < t0 + 9) @(posedge clk);
        #1 rst_n = 1'b0;
        run_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("reset_drain_no_done", 64'(done_n[0] + done_n[1]), 64'd0);

        for (int k = 0; k < 40; k++) begin
            l  = $urandom_range(40);
            ab = (l > 0 && $urandom_range(4) == 0) ? $urandom_range(l + 1, 1) : 0;
            run($urandom_range(3) == 0 ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom, $urandom, l,
                $urandom_range(3) == 0 ? 0 : 10, -1, -1, ab, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
